// File: rtl/mem_line_ctrl_pkg.sv
// Shared constants for the main-memory line controller: default geometry and FSM state encoding.
package mem_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int LAT    = 2;
  localparam int LINE_W = DATA_W * WORDS;
  localparam int OFF_W  = $clog2(WORDS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Cache-side request/response handshake plus the single-word bank port of the line controller.
interface mem_line_ctrl_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int WORDS  = mem_pkg::WORDS
);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W*WORDS-1:0]  req_wdata;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [DATA_W*WORDS-1:0]  resp_rdata;
  logic [ADDR_W-1:0]        bank_addr;
  logic                     bank_we;
  logic [DATA_W-1:0]        bank_wdata;
  logic [DATA_W-1:0]        bank_rdata;

  // Cache controller and memory bank side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, bank_rdata,
    input  req_ready, resp_valid, resp_rdata, bank_addr, bank_we, bank_wdata
  );

  // The line controller.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, bank_rdata,
    output req_ready, resp_valid, resp_rdata, bank_addr, bank_we, bank_wdata
  );

endinterface

// File: rtl/mem_line_buf.sv
// WORDS x DATA_W line buffer: load whole line, write one word, read one word and the packed line.
module mem_line_buf #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int WORDS  = mem_pkg::WORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [DATA_W*WORDS-1:0]    load_data,
  input  logic                       wr,
  input  logic [$clog2(WORDS)-1:0]   idx,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_word,
  output logic [DATA_W*WORDS-1:0]    line
);

  logic [DATA_W-1:0] mem [WORDS];

  // NOTE: this register file is reset on purpose; resp_rdata must read 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= load_data[i*DATA_W +: DATA_W];
    end else if (wr) begin
      mem[idx] <= wr_data;
    end
  end

  assign rd_word = mem[idx];

  // NOTE: default first so the packing loop cannot leave any bit unassigned (no latch).
  always_comb begin
    line = '0;
    for (int i = 0; i < WORDS; i++) line[i*DATA_W +: DATA_W] = mem[i];
  end

endmodule

// File: rtl/mem_line_ctrl.sv
// Cache-line to single-word bank sequencer with fixed per-word latency.
// Define MEM_CTRL_CRITICAL_WORD_FIRST_EN to start refill reads at the requested word offset.
module mem_line_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int WORDS  = mem_pkg::WORDS,
  parameter int LAT    = mem_pkg::LAT
) (
  input  logic            clk,
  input  logic            rst,
  mem_line_ctrl_if.slave  bus
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int LCNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [LCNT_W-1:0] LAT_LAST = (LAT > 0) ? LCNT_W'(LAT - 1) : '0;
  localparam logic [OFF_W:0]    ACC_LAST = (OFF_W + 1)'(WORDS - 1);
  localparam logic [1:0]        ST_AFTER_WORD = (LAT == 0) ? ST_ACCESS : ST_WAIT;

  logic [1:0]        state;
  logic [LCNT_W-1:0] lat_cnt;
  logic [OFF_W-1:0]  idx;
  logic [OFF_W:0]    acc_cnt;
  logic              is_write;
  logic [ADDR_W-1:0] line_base;
  logic [OFF_W-1:0]  start_off;
  logic [DATA_W-1:0] cur_word;
  logic              buf_load;
  logic              buf_wr;

`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
  assign start_off = bus.req_write ? '0 : bus.req_addr[OFF_W-1:0];
`else
  assign start_off = '0;
`endif

  assign buf_load = (state == ST_IDLE) && bus.req_valid && bus.req_write;
  assign buf_wr   = (state == ST_ACCESS) && !is_write;

  mem_line_buf #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (bus.req_wdata),
    .wr        (buf_wr),
    .idx       (idx),
    .wr_data   (bus.bank_rdata),
    .rd_word   (cur_word),
    .line      (bus.resp_rdata)
  );

  // Low base bits are always zero, so OR-ing the offset keeps the address inside the line.
  assign bus.bank_addr  = line_base | ADDR_W'(idx);
  assign bus.bank_we    = (state == ST_ACCESS) && is_write;
  assign bus.bank_wdata = cur_word;
  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      idx       <= '0;
      acc_cnt   <= '0;
      is_write  <= 1'b0;
      line_base <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            is_write  <= bus.req_write;
            line_base <= bus.req_addr & ~ADDR_W'(WORDS - 1);
            idx       <= start_off;
            acc_cnt   <= '0;
            lat_cnt   <= '0;
            state     <= ST_AFTER_WORD;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) state <= ST_ACCESS;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
        ST_ACCESS: begin
          // Offset wraps modulo WORDS by width alone; the base never sees a carry.
          idx     <= idx + 1'b1;
          lat_cnt <= '0;
          acc_cnt <= acc_cnt + 1'b1;
          state   <= (acc_cnt == ACC_LAST) ? ST_RESP : ST_AFTER_WORD;
        end
        ST_RESP: begin
          if (bus.resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Self-checking bench for mem_line_ctrl: vector table plus scoreboard, with LAT=2 and LAT=0 instances.
module tb_mem_line_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  always #5 clk = ~clk;

  mem_line_ctrl_if b  ();
  mem_line_ctrl_if b0 ();

  mem_line_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  mem_line_ctrl #(.LAT(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  // Bank models: 64 words, index = {addr[27], addr[4:0]} so the top line has its own slots.
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];

  function automatic logic [5:0] mi(input logic [27:0] a);
    return {a[27], a[4:0]};
  endfunction

  assign b.bank_rdata  = mem_a[mi(b.bank_addr)];
  assign b0.bank_rdata = mem_b[mi(b0.bank_addr)];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      mem_a[0]  <= 32'h50; mem_a[1]  <= 32'h60; mem_a[2]  <= 32'h70; mem_a[3]  <= 32'h80;
      mem_b[60] <= 32'h91; mem_b[61] <= 32'h92; mem_b[62] <= 32'h93; mem_b[63] <= 32'h94;
    end else begin
      if (b.bank_we)  mem_a[mi(b.bank_addr)]  <= b.bank_wdata;
      if (b0.bank_we) mem_b[mi(b0.bank_addr)] <= b0.bank_wdata;
    end
  end

  // Monitors: distinct bank addresses while busy, and every write strobe.
  logic [27:0] obs_q  [$];
  logic [27:0] obs0_q [$];
  logic [59:0] wr_q   [$];

  always @(negedge clk) begin
    if (!b.req_ready && !b.resp_valid && (obs_q.size() == 0 || obs_q[$] != b.bank_addr))
      obs_q.push_back(b.bank_addr);
    if (!b0.req_ready && !b0.resp_valid && (obs0_q.size() == 0 || obs0_q[$] != b0.bank_addr))
      obs0_q.push_back(b0.bank_addr);
    if (b.bank_we) wr_q.push_back({b.bank_addr, b.bank_wdata});
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [111:0] pack_ord(input logic [27:0] q [$]);
    logic [3:0][27:0] r;
    r = '1;
    for (int i = 0; i < 4; i++) if (i < q.size()) r[i] = q[i];
    return r;
  endfunction

  typedef struct {
    bit               wr;
    logic [27:0]      addr;
    logic [127:0]     wdata;
    logic [127:0]     exp;
    logic [3:0][27:0] ord;
  } vec_t;

  vec_t vecs [5];

  localparam logic [127:0] LINE0 = 128'h00000080_00000070_00000060_00000050;
  localparam logic [127:0] LINEW = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] LINET = 128'h00000094_00000093_00000092_00000091;

  // One request on the LAT=2 instance; hold=1 keeps resp_ready low for 5 cycles in RESP.
  task automatic run_req(input vec_t v, input bit hold, input string tag);
    int cnt;
    obs_q.delete();
    wr_q.delete();
    b.resp_ready = !hold;
    @(negedge clk);
    check({tag, "_ready_idle"}, b.req_ready, 1'b1);
    b.req_valid = 1'b1;
    b.req_write = v.wr;
    b.req_addr  = v.addr;
    b.req_wdata = v.wdata;
    exp_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    b.req_valid = 1'b0;
    cnt = 0;
    while (!b.resp_valid && cnt < 100) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, "_latency"}, cnt, 12);
    check({tag, "_rdata"}, b.resp_rdata, exp_q.pop_front());
    check({tag, "_naddr"}, obs_q.size(), 4);
    check({tag, "_order"}, pack_ord(obs_q), v.ord);
    if (v.wr) begin
      check({tag, "_nstrobe"}, wr_q.size(), 4);
      for (int i = 0; i < 4 && i < wr_q.size(); i++)
        check({tag, "_strobe"}, wr_q[i], {v.addr + 28'(i), v.wdata[i*32 +: 32]});
    end else begin
      check({tag, "_nstrobe"}, wr_q.size(), 0);
    end
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        b.req_valid = 1'b1;
        b.req_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_valid"}, b.resp_valid, 1'b1);
        check({tag, "_hold_ready"}, b.req_ready, 1'b0);
        check({tag, "_hold_rdata"}, b.resp_rdata, v.exp);
      end
      b.req_valid  = 1'b0;
      b.resp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_valid"}, b.resp_valid, 1'b0);
    check({tag, "_done_ready"}, b.req_ready, 1'b1);
  endtask

  initial begin
    int cnt;
    rst     = 1'b0;
    preload = 1'b1;
    b.req_valid = 1'b0; b.req_write = 1'b0; b.req_addr = '0; b.req_wdata = '0; b.resp_ready = 1'b1;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.resp_ready = 1'b1;

    vecs[0] = '{wr: 1'b0, addr: 28'h0,  wdata: '0,    exp: LINE0, ord: {28'h3, 28'h2, 28'h1, 28'h0}};
    vecs[1] = '{wr: 1'b1, addr: 28'h10, wdata: LINEW, exp: LINEW, ord: {28'h13, 28'h12, 28'h11, 28'h10}};
    vecs[2] = '{wr: 1'b0, addr: 28'h10, wdata: '0,    exp: LINEW, ord: {28'h13, 28'h12, 28'h11, 28'h10}};
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
    vecs[3] = '{wr: 1'b0, addr: 28'h2,  wdata: '0,    exp: LINE0, ord: {28'h1, 28'h0, 28'h3, 28'h2}};
    vecs[4] = '{wr: 1'b0, addr: 28'h13, wdata: '0,    exp: LINEW, ord: {28'h12, 28'h11, 28'h10, 28'h13}};
`else
    vecs[3] = '{wr: 1'b0, addr: 28'h2,  wdata: '0,    exp: LINE0, ord: {28'h3, 28'h2, 28'h1, 28'h0}};
    vecs[4] = '{wr: 1'b0, addr: 28'h13, wdata: '0,    exp: LINEW, ord: {28'h13, 28'h12, 28'h11, 28'h10}};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  b.req_ready,  1'b1);
    check("rst_resp_valid", b.resp_valid, 1'b0);
    check("rst_bank_we",    b.bank_we,    1'b0);
    check("rst_bank_addr",  b.bank_addr,  28'h0);
    check("rst_bank_wdata", b.bank_wdata, 32'h0);
    check("rst_resp_rdata", b.resp_rdata, 128'h0);
    rst     = 1'b1;
    preload = 1'b0;

    for (int i = 0; i < 5; i++) run_req(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Back-pressure in RESP.
    run_req(vecs[0], 1'b1, "hold");

    // Reset in the middle of the second word of a write.
    wr_q.delete();
    @(negedge clk);
    b.req_valid = 1'b1;
    b.req_write = 1'b1;
    b.req_addr  = 28'h8;
    b.req_wdata = 128'h00000014_00000013_00000012_00000011;
    @(posedge clk);
    @(negedge clk);
    b.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_we",   b.bank_we,   1'b1);
    check("mid_addr", b.bank_addr, 28'h9);
    rst = 1'b0;
    #1;
    check("arst_we",    b.bank_we,    1'b0);
    check("arst_valid", b.resp_valid, 1'b0);
    check("arst_ready", b.req_ready,  1'b1);
    check("arst_addr",  b.bank_addr,  28'h0);
    check("arst_rdata", b.resp_rdata, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_word0",   mem_a[8],  32'h11);
    check("arst_word1",   mem_a[9],  32'h0);
    check("arst_word2",   mem_a[10], 32'h0);
    check("arst_word3",   mem_a[11], 32'h0);
    check("arst_nstrobe", wr_q.size(), 1);
    check("arst_idle",    b.req_ready, 1'b1);

    // LAT=0 instance, top-of-memory line.
    obs0_q.delete();
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.req_write = 1'b0;
    b0.req_addr  = 28'hFFFFFFE;
    exp_q.push_back(LINET);
    @(posedge clk);
    @(negedge clk);
    b0.req_valid = 1'b0;
    cnt = 0;
    while (!b0.resp_valid && cnt < 100) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check("lat0_latency", cnt, 4);
    check("lat0_rdata",   b0.resp_rdata, exp_q.pop_front());
    check("lat0_naddr",   obs0_q.size(), 4);
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
    check("lat0_order", pack_ord(obs0_q), {28'hFFFFFFD, 28'hFFFFFFC, 28'hFFFFFFF, 28'hFFFFFFE});
`else
    check("lat0_order", pack_ord(obs0_q), {28'hFFFFFFF, 28'hFFFFFFE, 28'hFFFFFFD, 28'hFFFFFFC});
`endif
    @(posedge clk);
    @(negedge clk);
    check("lat0_done", b0.req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
